operand_transformer: RTL and testbench

// - Single-stage pipelined operand pre-scaler for the MX datapath.
// - Accepts a block of 32 sign-magnitude int8 elements plus 16 shared micro-scales.
// - Left-shifts each element magnitude by its shared micro-scale, saturating by MSB alignment.
// - Emits the 32 transformed elements with valid/ready handshakes on both sides.

---
 rtl/operand_tf_pkg.sv | 37 +++
 rtl/operand_shift_unit.sv | 34 +++
 rtl/operand_transformer.sv | 59 +++++
 tb/tb_operand_transformer.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_tf_pkg.sv
// Shared types and constants for the MX operand pre-scaler.
// Element encoding is sign-magnitude int8: bit 7 is the sign, bits 6:0 the magnitude.
package operand_tf_pkg;

    localparam int NUM_ELEMS  = 32;
    localparam int NUM_SCALES = 16;
    localparam int ELEM_W     = 8;
    localparam int SCALE_W    = 8;
    localparam int MAG_W      = ELEM_W - 1;

    typedef struct packed {
        logic scale_sharing_mode;
    } operand_cfg_t;

    typedef struct packed {
        operand_cfg_t                               cfg;
        logic [NUM_ELEMS-1:0][ELEM_W-1:0]           elements;
        logic [NUM_SCALES-1:0][SCALE_W-1:0]         micro_scales;
    } operand_input_t;

    typedef struct packed {
        logic [NUM_ELEMS-1:0][ELEM_W-1:0]           flattened_elements;
    } operand_output_t;

    // Index of the highest set bit; returns 0 for a zero magnitude.
    function automatic logic [2:0] leading_one_idx(input logic [MAG_W-1:0] mag);
        logic [2:0] idx;
        idx = 3'd0;
        for (int b = 0; b < MAG_W; b++) begin
            if (mag[b]) begin
                idx = b[2:0];
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/operand_shift_unit.sv
// Per-element left shift of the magnitude by its micro-scale, clamped so the
// leading one never moves past bit 6. The sign bit is passed straight through.
module operand_shift_unit
    import operand_tf_pkg::*;
(
    input  logic [ELEM_W-1:0]  elem,
    input  logic [SCALE_W-1:0] scale,
    output logic [ELEM_W-1:0]  result
);

    logic [MAG_W-1:0] mag;
    logic [2:0]       lead;
    logic [8:0]       msb_pos;
    logic [2:0]       shamt;

    assign mag     = elem[MAG_W-1:0];
    assign lead    = leading_one_idx(mag);
    // Nine bits so a scale of 255 plus a lead of 6 cannot wrap.
    assign msb_pos = {6'd0, lead} + {1'b0, scale};

    always_comb begin
        shamt = 3'd0;
        if (mag != '0) begin
            if (msb_pos > 9'd6) begin
                shamt = 3'd6 - lead;
            end else begin
                shamt = scale[2:0];
            end
        end
    end

    assign result = {elem[ELEM_W-1], mag << shamt};

endmodule

// File: rtl/operand_transformer.sv
// Single-stage operand pre-scaler: picks each element's shared micro-scale,
// shifts all 32 elements in parallel and holds the result behind a valid/ready register.
module operand_transformer
    import operand_tf_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_in,
    output logic            ready_in,
    input  operand_input_t  data_in,
    output logic            valid_out,
    input  logic            ready_out,
    output operand_output_t data_out
);

    logic            valid_reg;
    operand_output_t data_reg;
    operand_output_t data_next;
    logic            accept;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_lane
            localparam int IDX_PAIR = gi / 2;
            localparam int IDX_QUAD = gi / 4;

            logic [SCALE_W-1:0] lane_scale;

            // In 1:4 sharing only the lower eight micro-scales are referenced.
            assign lane_scale = data_in.cfg.scale_sharing_mode ? data_in.micro_scales[IDX_QUAD]
                                                               : data_in.micro_scales[IDX_PAIR];

            operand_shift_unit u_shift (
                .elem   (data_in.elements[gi]),
                .scale  (lane_scale),
                .result (data_next.flattened_elements[gi])
            );
        end
    endgenerate

    assign ready_in = !valid_reg || ready_out;
    assign accept   = valid_in && ready_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
            data_reg  <= '0;
        end else if (accept) begin
            valid_reg <= 1'b1;
            data_reg  <= data_next;
        end else if (ready_out) begin
            valid_reg <= 1'b0;
        end
    end

    assign valid_out = valid_reg;
    assign data_out  = data_reg;

endmodule

// File: tb/tb_operand_transformer.sv
// Randomised and directed checks of operand_transformer against a behavioural
// model that normalises each magnitude by repeated doubling.
module tb_operand_transformer;
    import operand_tf_pkg::*;

    logic            clk;
    logic            rst_n;
    logic            valid_in;
    logic            ready_in;
    operand_input_t  data_in;
    logic            valid_out;
    logic            ready_out;
    operand_output_t data_out;

    int compared;
    int mismatched;

    operand_transformer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid_in  (valid_in),
        .ready_in  (ready_in),
        .data_in   (data_in),
        .valid_out (valid_out),
        .ready_out (ready_out),
        .data_out  (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Double the magnitude up to `scale` times, stopping before it would exceed 7 bits.
    function automatic operand_output_t model(input operand_input_t x);
        operand_output_t r;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            int sc;
            int m;
            sc = x.cfg.scale_sharing_mode ? int'(x.micro_scales[i / 4]) : int'(x.micro_scales[i / 2]);
            m  = int'(x.elements[i][6:0]);
            if (m != 0) begin
                for (int n = 0; n < sc; n++) begin
                    if (m * 2 > 127) break;
                    m = m * 2;
                end
            end
            r.flattened_elements[i] = {x.elements[i][7], m[6:0]};
        end
        return r;
    endfunction

    function automatic operand_input_t rand_block();
        operand_input_t b;
        b.cfg.scale_sharing_mode = 1'($urandom_range(0, 1));
        for (int i = 0; i < NUM_ELEMS; i++) b.elements[i] = 8'($urandom);
        for (int l = 0; l < NUM_SCALES; l++) begin
            b.micro_scales[l] = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 8));
        end
        return b;
    endfunction

    // Push one block with ready_out=1 and return the output seen one cycle later.
    task automatic send_one(input operand_input_t blk, output logic v, output operand_output_t d);
        @(negedge clk);
        data_in   = blk;
        valid_in  = 1'b1;
        ready_out = 1'b1;
        @(negedge clk);
        valid_in = 1'b0;
        v = valid_out;
        d = data_out;
    endtask

    task automatic test_reset();
        rst_n     = 1'b1;
        valid_in  = 1'b0;
        ready_out = 1'b0;
        data_in   = '0;
        #2 rst_n  = 1'b0;
        #1;
        compared++;
        if (valid_out !== 1'b0 || data_out !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs: valid_out=%b data_out=%h required valid_out=0 data_out=0", valid_out, data_out);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (ready_in !== 1'b1) begin
            mismatched++;
            $display("FAIL reset_ready_in: got %b required 1", ready_in);
        end
        $display("tx reset: valid_out=%b ready_in=%b", valid_out, ready_in);
    endtask

    task automatic test_pattern_mode0();
        operand_input_t  blk;
        operand_output_t got;
        operand_output_t exp;
        logic            v;
        blk = '0;
        blk.cfg.scale_sharing_mode = 1'b0;
        for (int i = 0; i < NUM_ELEMS; i++) begin
            int k;
            k = i % 8;
            blk.elements[i] = 8'((1 << (k + 1)) - 1);
            if (i >= 16) blk.elements[i][7] = 1'b1;
        end
        for (int l = 0; l < NUM_SCALES; l++) blk.micro_scales[l] = 8'(l / 4);
        exp = model(blk);
        send_one(blk, v, got);
        compared++;
        if (v !== 1'b1 || got !== exp) begin
            mismatched++;
            $display("FAIL pattern_mode0: valid=%b got %h required %h", v, got, exp);
        end
        $display("tx pattern_mode0: out=%h", got);
    endtask

    task automatic test_directed_values();
        operand_input_t  blk;
        operand_output_t got;
        logic            v;
        logic [7:0]      exp_val [8];
        logic [7:0]      elem_val[8];
        logic [7:0]      scl_val [8];
        elem_val = '{8'h07, 8'h1F, 8'h8F, 8'hFF, 8'h00, 8'h80, 8'h01, 8'h7F};
        scl_val  = '{8'd1,  8'd3,  8'd3,  8'd3,  8'd9,  8'd255, 8'd200, 8'd0};
        exp_val  = '{8'h0E, 8'h7C, 8'hF8, 8'hFF, 8'h00, 8'h80, 8'h40, 8'h7F};
        blk = '0;
        for (int j = 0; j < 8; j++) begin
            blk.elements[2 * j]     = elem_val[j];
            blk.elements[2 * j + 1] = elem_val[j];
            blk.micro_scales[j]     = scl_val[j];
        end
        send_one(blk, v, got);
        for (int j = 0; j < 8; j++) begin
            compared++;
            if (v !== 1'b1 || got.flattened_elements[2 * j] !== exp_val[j]) begin
                mismatched++;
                $display("FAIL directed_%0d: elem %h scale %0d got %h required %h",
                         j, elem_val[j], scl_val[j], got.flattened_elements[2 * j], exp_val[j]);
            end
        end
        $display("tx directed: out=%h", got);
    endtask

    task automatic test_mode1();
        operand_input_t  blk;
        operand_output_t got;
        operand_output_t exp;
        logic            v;
        blk = rand_block();
        blk.cfg.scale_sharing_mode = 1'b1;
        blk.elements[5]     = 8'h03;
        blk.micro_scales[1] = 8'd2;
        blk.micro_scales[2] = 8'd0;
        exp = model(blk);
        send_one(blk, v, got);
        compared++;
        if (got.flattened_elements[5] !== 8'h0C) begin
            mismatched++;
            $display("FAIL mode1_elem5: got %h required 0c", got.flattened_elements[5]);
        end
        compared++;
        if (v !== 1'b1 || got !== exp) begin
            mismatched++;
            $display("FAIL mode1_block: valid=%b got %h required %h", v, got, exp);
        end
        $display("tx mode1: out=%h", got);
    endtask

    task automatic test_random();
        operand_output_t got;
        operand_output_t exp;
        operand_input_t  blk;
        logic            v;
        for (int t = 0; t < 20; t++) begin
            blk = rand_block();
            exp = model(blk);
            send_one(blk, v, got);
            compared++;
            if (v !== 1'b1 || got !== exp) begin
                mismatched++;
                $display("FAIL random_%0d: valid=%b got %h required %h", t, v, got, exp);
            end
            $display("tx random_%0d: mode=%b out=%h", t, blk.cfg.scale_sharing_mode, got);
        end
    endtask

    task automatic test_backpressure();
        operand_input_t  blk;
        operand_output_t exp;
        blk = rand_block();
        exp = model(blk);
        @(negedge clk);
        data_in   = blk;
        valid_in  = 1'b1;
        ready_out = 1'b0;
        @(negedge clk);
        // A competing block stays offered; it must not be taken while stalled.
        data_in = rand_block();
        for (int c = 0; c < 10; c++) begin
            compared++;
            if (valid_out !== 1'b1 || data_out !== exp || ready_in !== 1'b0) begin
                mismatched++;
                $display("FAIL backpressure_%0d: valid_out=%b ready_in=%b data=%h required 1/0/%h",
                         c, valid_out, ready_in, data_out, exp);
            end
            @(negedge clk);
        end
        valid_in  = 1'b0;
        ready_out = 1'b1;
        @(negedge clk);
        compared++;
        if (valid_out !== 1'b0) begin
            mismatched++;
            $display("FAIL backpressure_release: valid_out=%b required 0", valid_out);
        end
        $display("tx backpressure: held %h for 10 cycles", exp);
    endtask

    task automatic test_back_to_back();
        operand_output_t q[$];
        operand_output_t e;
        int              pops;
        pops = 0;
        for (int cyc = 0; cyc < 260; cyc++) begin
            @(negedge clk);
            compared++;
            if (valid_out !== (q.size() != 0)) begin
                mismatched++;
                $display("FAIL b2b_valid cyc %0d: valid_out=%b required %b", cyc, valid_out, q.size() != 0);
            end
            valid_in  = (cyc < 200) && ($urandom_range(0, 3) != 0);
            data_in   = rand_block();
            ready_out = (cyc >= 200) || ($urandom_range(0, 2) != 0);
            #1;
            compared++;
            if (ready_in !== (q.size() == 0 || ready_out)) begin
                mismatched++;
                $display("FAIL b2b_ready_in cyc %0d: got %b required %b", cyc, ready_in, q.size() == 0 || ready_out);
            end
            if (valid_out && ready_out && q.size() != 0) begin
                e = q.pop_front();
                pops++;
                compared++;
                if (data_out !== e) begin
                    mismatched++;
                    $display("FAIL b2b_data pop %0d: got %h required %h", pops, data_out, e);
                end
                $display("tx b2b pop %0d: out=%h", pops, data_out);
            end
            if (valid_in && ready_in) q.push_back(model(data_in));
        end
        valid_in = 1'b0;
        compared++;
        if (q.size() != 0) begin
            mismatched++;
            $display("FAIL b2b_drain: %0d blocks still expected, required 0", q.size());
        end
    endtask

    task automatic test_reset_mid();
        operand_input_t blk;
        blk = rand_block();
        blk.elements[0] = 8'h41;
        @(negedge clk);
        data_in   = blk;
        valid_in  = 1'b1;
        ready_out = 1'b0;
        @(negedge clk);
        valid_in = 1'b0;
        compared++;
        if (valid_out !== 1'b1 || data_out === '0) begin
            mismatched++;
            $display("FAIL reset_mid_pre: valid_out=%b data=%h required held nonzero block", valid_out, data_out);
        end
        #2 rst_n = 1'b0;
        #1;
        compared++;
        if (valid_out !== 1'b0 || data_out !== '0) begin
            mismatched++;
            $display("FAIL reset_mid: valid_out=%b data=%h required 0/0", valid_out, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (ready_in !== 1'b1 || valid_out !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_release: ready_in=%b valid_out=%b required 1/0", ready_in, valid_out);
        end
        $display("tx reset_mid: valid_out=%b", valid_out);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        test_reset();
        test_pattern_mode0();
        test_directed_values();
        test_mode1();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
